// File: rtl/pixel_frame_writer.sv
// rtl/pixel_frame_writer.sv - pixel stream / full-frame fill writer for the 160x120 frame RAM
// Optional feature macro: PIXEL_CLIP_EN (discard off-screen pixels and count them)
module pixel_frame_writer #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int COLOUR_W   = 9,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          iX,
  input  logic [6:0]          iY,
  input  logic [COLOUR_W-1:0] iColour,
  input  logic                iPlot,
  output logic                oReady,
  input  logic                clearScreenEnable,
  input  logic [COLOUR_W-1:0] iClearColour,
  output logic                clearScreenDone,
  input  logic                iWrGrant,
  output logic                wrEn,
  output logic [ADDR_W-1:0]   wrAddress,
  output logic [COLOUR_W-1:0] wrData,
  output logic [7:0]          droppedCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 8 + 7 + COLOUR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_CLR_WAIT, S_CLEAR, S_DONE} state_t;
  state_t state, state_nxt;

  logic [ENT_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic                empty, full, push, pop, load_ok, clip;
  logic [7:0]          head_x;
  logic [6:0]          head_y;
  logic [COLOUR_W-1:0] head_c;
  logic [22:0]         addr_full;
  logic                wr_en_nxt;
  logic [ADDR_W-1:0]   wr_addr_nxt;
  logic [COLOUR_W-1:0] wr_data_nxt;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign oReady  = !full && (state == S_IDLE || state == S_RUN);
  assign push    = iPlot && oReady;
  // The write register may take a new word when idle or when its current word is granted.
  assign load_ok = !wrEn || iWrGrant;
  assign {head_x, head_y, head_c} = mem[rd_ptr];
  // Full-precision row-major address, truncated to the RAM address width.
  assign addr_full = 23'(head_y) * 23'(WIDTH) + 23'(head_x);
  assign clearScreenDone = (state == S_DONE);

`ifdef PIXEL_CLIP_EN
  assign clip = (32'(head_x) >= WIDTH) || (32'(head_y) >= HEIGHT);

  // Saturating count of pixels discarded at pop time.
  always_ff @(posedge clock) begin
    if (reset)
      droppedCount <= '0;
    else if (pop && clip && droppedCount != 8'hFF)
      droppedCount <= droppedCount + 8'd1;
  end
`else
  assign clip = 1'b0;
  assign droppedCount = '0;
`endif

  // Queue storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= {iX, iY, iColour};
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // State and write register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      wrEn      <= 1'b0;
      wrAddress <= '0;
      wrData    <= '0;
    end else begin
      state     <= state_nxt;
      wrEn      <= wr_en_nxt;
      wrAddress <= wr_addr_nxt;
      wrData    <= wr_data_nxt;
    end
  end

  // Next state, queue pop and next write-register contents.
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    wr_en_nxt   = wrEn;
    wr_addr_nxt = wrAddress;
    wr_data_nxt = wrData;
    case (state)
      S_IDLE, S_RUN, S_CLR_WAIT: begin
        if (load_ok) begin
          pop       = !empty;
          wr_en_nxt = !empty && !clip;
          if (!empty) begin
            wr_addr_nxt = addr_full[ADDR_W-1:0];
            wr_data_nxt = head_c;
          end
        end
        if (state == S_CLR_WAIT) begin
          if (!clearScreenEnable) begin
            state_nxt = empty ? S_IDLE : S_RUN;
          end else if (empty && load_ok) begin
            // Pixel traffic has fully drained: start the fill at address 0.
            state_nxt   = S_CLEAR;
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = '0;
            wr_data_nxt = iClearColour;
          end
        end else if (clearScreenEnable) begin
          state_nxt = S_CLR_WAIT;
        end else if (state == S_IDLE && !empty) begin
          state_nxt = S_RUN;
        end else if (state == S_RUN && empty && load_ok) begin
          state_nxt = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (!clearScreenEnable) begin
          state_nxt = empty ? S_IDLE : S_RUN;
          wr_en_nxt = 1'b0;
        end else if (iWrGrant) begin
          if (wrAddress == LAST_ADDR) begin
            state_nxt = S_DONE;
            wr_en_nxt = 1'b0;
          end else begin
            wr_addr_nxt = wrAddress + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        wr_en_nxt = 1'b0;
        if (!clearScreenEnable) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
